// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ  = 3'd0,
    PC_JMP  = 3'd1,
    PC_BRR  = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4,
    PC_HOLD = 3'd5
  } pc_op_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO; only the occupancy count is reset, entry contents are don't-care.
module pc_ret_stack #(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] cnt_m1;

  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);
  assign cnt_m1 = cnt - CNT_W'(1);
  assign top    = mem[cnt_m1[IDX_W-1:0]];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt <= cnt_m1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[cnt[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: combinational next-PC select, range checks,
// sticky error flags and the registered instruction address.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int LAST_ADDR   = 63,
  parameter int RESET_ADDR  = 0,
  parameter int OFS_W       = 6,
  parameter int STACK_DEPTH = 4,
  localparam int CNT_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              en,
  input  pc_op_t            op,
  input  logic [ADDR_W-1:0] target,
  input  logic [OFS_W-1:0]  offset,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [CNT_W-1:0]  stack_cnt,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err_ovf,
  output logic              err_unf,
  output logic              err_range
);

  // Wide enough that addr + offset can never wrap before the sign/limit test.
  localparam int SW = max_int(ADDR_W, OFS_W) + 2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] RST  = ADDR_W'(RESET_ADDR);

  logic [ADDR_W-1:0] inc, nxt_addr, top;
  logic signed [SW-1:0] brr_dest;
  logic brr_bad, tgt_bad;
  logic push, pop, set_ovf, set_unf, set_rng;

  assign inc      = (instr_addr == LAST) ? '0 : instr_addr + ADDR_W'(1);
  assign brr_dest = $signed({{(SW-ADDR_W){1'b0}}, instr_addr})
                  + $signed({{(SW-OFS_W){offset[OFS_W-1]}}, offset});
  assign brr_bad  = brr_dest[SW-1] | (brr_dest[SW-2:0] > (SW-1)'(LAST_ADDR));
  assign tgt_bad  = (target > LAST);

  always_comb begin
    nxt_addr = instr_addr;
    push     = 1'b0;
    pop      = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    set_rng  = 1'b0;
    if (en) begin
      case (op)
        PC_SEQ: nxt_addr = inc;
        PC_JMP: begin
          nxt_addr = tgt_bad ? '0 : target;
          set_rng  = tgt_bad;
        end
        PC_BRR: begin
          nxt_addr = brr_bad ? '0 : brr_dest[ADDR_W-1:0];
          set_rng  = brr_bad;
        end
        PC_CALL: begin
          // A full stack turns the call into a plain step; the target is not evaluated.
          if (stack_full) begin
            nxt_addr = inc;
            set_ovf  = 1'b1;
          end else begin
            push     = 1'b1;
            nxt_addr = tgt_bad ? '0 : target;
            set_rng  = tgt_bad;
          end
        end
        PC_RET: begin
          if (stack_empty) begin
            nxt_addr = inc;
            set_unf  = 1'b1;
          end else begin
            pop      = 1'b1;
            nxt_addr = top;
          end
        end
        default: nxt_addr = instr_addr;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      instr_addr <= RST;
      err_ovf    <= 1'b0;
      err_unf    <= 1'b0;
      err_range  <= 1'b0;
    end else begin
      instr_addr <= nxt_addr;
      err_ovf    <= err_ovf | set_ovf;
      err_unf    <= err_unf | set_unf;
      err_range  <= err_range | set_rng;
    end
  end

  pc_ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock   (clock),
    .clear_n (clear_n),
    .push    (push),
    .pop     (pop),
    .din     (inc),
    .top     (top),
    .cnt     (stack_cnt),
    .full    (stack_full),
    .empty   (stack_empty)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: default instance plus a LAST_ADDR=19 instance, both
// driven identically and compared against an integer reference model.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       en;
  pc_op_t     op;
  logic [5:0] target, offset;

  logic [5:0] addr0, addr1;
  logic [2:0] cnt0, cnt1;
  logic full0, empty0, ovf0, unf0, rng0;
  logic full1, empty1, ovf1, unf1, rng1;

  int total = 0;
  int bad   = 0;

  int m_addr[2], m_cnt[2], m_ovf[2], m_unf[2], m_rng[2];
  int m_stk[2][4];

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock(clock), .clear_n(clear_n), .en(en), .op(op), .target(target), .offset(offset),
    .instr_addr(addr0), .stack_cnt(cnt0), .stack_full(full0), .stack_empty(empty0),
    .err_ovf(ovf0), .err_unf(unf0), .err_range(rng0)
  );

  pc_sequencer #(.LAST_ADDR(19)) dut19 (
    .clock(clock), .clear_n(clear_n), .en(en), .op(op), .target(target), .offset(offset),
    .instr_addr(addr1), .stack_cnt(cnt1), .stack_full(full1), .stack_empty(empty1),
    .err_ovf(ovf1), .err_unf(unf1), .err_range(rng1)
  );

  function automatic int last_of(input int i);
    return (i == 0) ? 63 : 19;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_rng[i] = 0;
    end
  endtask

  task automatic model_step(input logic e, input pc_op_t o, input logic [5:0] t, input logic [5:0] ofs);
    int a, nx, lim, so;
    so = $signed(ofs);
    for (int i = 0; i < 2; i++) begin
      a   = m_addr[i];
      lim = last_of(i);
      nx  = (a == lim) ? 0 : a + 1;
      if (e) begin
        case (o)
          PC_SEQ: m_addr[i] = nx;
          PC_JMP: if (int'(t) > lim) begin m_addr[i] = 0; m_rng[i] = 1; end
                  else m_addr[i] = t;
          PC_BRR: if (a + so < 0 || a + so > lim) begin m_addr[i] = 0; m_rng[i] = 1; end
                  else m_addr[i] = a + so;
          PC_CALL: if (m_cnt[i] == 4) begin m_addr[i] = nx; m_ovf[i] = 1; end
                   else begin
                     m_stk[i][m_cnt[i]] = nx;
                     m_cnt[i]++;
                     if (int'(t) > lim) begin m_addr[i] = 0; m_rng[i] = 1; end
                     else m_addr[i] = t;
                   end
          PC_RET: if (m_cnt[i] == 0) begin m_addr[i] = nx; m_unf[i] = 1; end
                  else begin m_cnt[i]--; m_addr[i] = m_stk[i][m_cnt[i]]; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":addr"},  addr0,  m_addr[0]);
    chk({ctx, ":cnt"},   cnt0,   m_cnt[0]);
    chk({ctx, ":full"},  full0,  (m_cnt[0] == 4));
    chk({ctx, ":empty"}, empty0, (m_cnt[0] == 0));
    chk({ctx, ":ovf"},   ovf0,   m_ovf[0]);
    chk({ctx, ":unf"},   unf0,   m_unf[0]);
    chk({ctx, ":rng"},   rng0,   m_rng[0]);
    chk({ctx, ":addr19"}, addr1, m_addr[1]);
    chk({ctx, ":cnt19"},  cnt1,  m_cnt[1]);
    chk({ctx, ":ovf19"},  ovf1,  m_ovf[1]);
    chk({ctx, ":unf19"},  unf1,  m_unf[1]);
    chk({ctx, ":rng19"},  rng1,  m_rng[1]);
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the next one.
  task automatic step(input string ctx, input logic e, input pc_op_t o,
                      input logic [5:0] t, input logic [5:0] ofs);
    en = e; op = o; target = t; offset = ofs;
    @(posedge clock);
    model_step(e, o, t, ofs);
    #1;
    check_all(ctx);
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    #2;
    model_reset();
    chk("rst:addr", addr0, 0);
    chk("rst:cnt", cnt0, 0);
    chk("rst:empty", empty0, 1);
    chk("rst:errs", {ovf0, unf0, rng0, ovf1, unf1, rng1}, 0);
    clear_n = 1'b1;
    #1;
  endtask

  initial begin
    int adv;
    clear_n = 1'b0; en = 1'b0; op = PC_SEQ; target = '0; offset = '0;
    model_reset();
    #3;
    chk("init:addr", addr0, 0);
    chk("init:full", full0, 0);
    clear_n = 1'b1;
    @(posedge clock); #1;

    // Wrap at LAST_ADDR=19, then an out-of-range jump
    do_reset();
    for (int k = 0; k < 18; k++) step("w19", 1'b1, PC_SEQ, 6'd0, 6'd0);
    chk("w19:at18", addr1, 18);
    step("w19", 1'b1, PC_SEQ, 6'd0, 6'd0);
    chk("w19:at19", addr1, 19);
    step("w19", 1'b1, PC_SEQ, 6'd0, 6'd0);
    chk("w19:wrap", addr1, 0);
    chk("w19:def20", addr0, 20);
    step("w19", 1'b1, PC_JMP, 6'd25, 6'd0);
    chk("w19:jmp_addr", addr1, 0);
    chk("w19:jmp_rng", rng1, 1);
    chk("w19:jmp_def", addr0, 25);
    step("w19", 1'b1, PC_SEQ, 6'd0, 6'd0);
    chk("w19:rng_sticky", rng1, 1);

    // Sequential run with a 3-cycle stall
    do_reset();
    adv = 0;
    for (int k = 0; k < 70; k++) begin
      if (k >= 30 && k < 33) step("seq", 1'b0, pc_op_t'($urandom_range(0, 7)), 6'd9, 6'd9);
      else begin step("seq", 1'b1, PC_SEQ, 6'd0, 6'd0); adv++; end
      chk("seq:count", addr0, adv % 64);
    end

    // Relative branches
    do_reset();
    step("brr", 1'b1, PC_JMP, 6'd10, 6'd0);
    step("brr", 1'b1, PC_BRR, 6'd0, 6'h3D);
    chk("brr:m3", addr0, 7);
    step("brr", 1'b1, PC_BRR, 6'd0, 6'd31);
    chk("brr:p31", addr0, 38);
    step("brr", 1'b1, PC_JMP, 6'd5, 6'd0);
    step("brr", 1'b1, PC_BRR, 6'd0, 6'h38);
    chk("brr:neg_addr", addr0, 0);
    chk("brr:neg_rng", rng0, 1);

    // Nested call / return
    do_reset();
    step("call", 1'b1, PC_JMP, 6'd2, 6'd0);
    step("call", 1'b1, PC_CALL, 6'd40, 6'd0);
    chk("call:c1", addr0, 40);
    chk("call:n1", cnt0, 1);
    step("call", 1'b1, PC_CALL, 6'd50, 6'd0);
    chk("call:c2", addr0, 50);
    chk("call:n2", cnt0, 2);
    step("call", 1'b1, PC_RET, 6'd0, 6'd0);
    chk("call:r1", addr0, 41);
    step("call", 1'b1, PC_RET, 6'd0, 6'd0);
    chk("call:r2", addr0, 3);
    chk("call:empty", empty0, 1);

    // Overflow then underflow
    do_reset();
    for (int k = 1; k <= 4; k++) step("ovf", 1'b1, PC_CALL, 6'(10 * k), 6'd0);
    chk("ovf:full", full0, 1);
    chk("ovf:at40", addr0, 40);
    step("ovf", 1'b1, PC_CALL, 6'd50, 6'd0);
    chk("ovf:addr", addr0, 41);
    chk("ovf:flag", ovf0, 1);
    chk("ovf:cnt", cnt0, 4);
    for (int k = 0; k < 4; k++) step("ovf", 1'b1, PC_RET, 6'd0, 6'd0);
    chk("ovf:drained", addr0, 1);
    step("unf", 1'b1, PC_RET, 6'd0, 6'd0);
    chk("unf:addr", addr0, 2);
    chk("unf:flag", unf0, 1);

    // Async reset between edges
    do_reset();
    step("ar", 1'b1, PC_CALL, 6'd10, 6'd0);
    step("ar", 1'b1, PC_CALL, 6'd20, 6'd0);
    step("ar", 1'b1, PC_CALL, 6'd33, 6'd0);
    chk("ar:pre_addr", addr0, 33);
    chk("ar:pre_cnt", cnt0, 3);
    en = 1'b1; op = PC_RET;
    #2;
    clear_n = 1'b0;
    #1;
    chk("ar:addr", addr0, 0);
    chk("ar:cnt", cnt0, 0);
    chk("ar:empty", empty0, 1);
    chk("ar:errs", {ovf0, unf0, rng0}, 0);
    clear_n = 1'b1;
    model_reset();
    #1;
    check_all("ar_post");

    // Randomized operations, including undefined encodings and stalls
    for (int k = 0; k < 400; k++) begin
      if (k % 80 == 0) do_reset();
      step("rnd", ($urandom_range(0, 7) != 0), pc_op_t'($urandom_range(0, 7)),
           6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
